// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states and result-ready levels.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; one quotient bit per cycle and
// a combinational stall request that holds EX until the result is ready.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sgn_q, sgn_d;
  logic               neg1_q, neg1_d;
  logic               neg2_q, neg2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH+1:0]   trial;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH:0]     rem_step;
  logic [WIDTH-1:0]   quot_step;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;

    // The dividend register doubles as the quotient shift register.
    trial     = {rem_q, dvd_q[WIDTH-1]};
    diff      = trial - {2'b00, dvs_q};
    rem_step  = diff[WIDTH+1] ? trial[WIDTH:0] : diff[WIDTH:0];
    quot_step = {dvd_q[WIDTH-2:0], ~diff[WIDTH+1]};
    quot_fix  = (sgn_q & (neg1_q ^ neg2_q)) ? -quot_step : quot_step;
    rem_fix   = (sgn_q & neg1_q) ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];

    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        cnt_d    = '0;
        rem_d    = '0;
        if (start_i & ~annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            sgn_d   = signed_i;
            neg1_d  = opdata1_i[WIDTH-1];
            neg2_d  = opdata2_i[WIDTH-1];
            dvd_d   = (signed_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
            dvs_d   = (signed_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
          end
        end
      end
      DivByZero: begin
        if (annul_i | ~start_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          ready_d  = DivResultReady;
          result_d = '0;
        end
      end
      DivOn: begin
        if (annul_i | ~start_i) begin
          state_d = DivFree;
        end else begin
          rem_d = rem_step;
          dvd_d = quot_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DivEnd;
            ready_d  = DivResultReady;
            result_d = {rem_fix, quot_fix};
          end
        end
      end
      DivEnd: begin
        if (annul_i | ~start_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      sgn_q    <= sgn_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i & ~rst;

endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit: results and latencies are predicted
// from plain integer arithmetic and checked by an independent monitor.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rise_cnt = 0;
  logic prev_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: quotient truncates toward zero, remainder follows the dividend.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sbv;
    if (b == 32'd0) return 64'd0;
    if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa  = a;
      sbv = b;
      q   = sa / sbv;
      r   = sa % sbv;
    end
    return {r, q};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (ready_o && !prev_ready) begin
      rise_cnt <= rise_cnt + 1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got result %h expected no result (cycle %0d)", result_o, cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, result_o, e.res);
        check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
        $display("txn %s: result %h expected %h at cycle %0d (due %0d)", e.name, result_o, e.res, cyc, e.due);
      end
    end
    prev_ready <= ready_o;
  end

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input string name);
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    sb.push_back('{ref_div(s, a, b), cyc + ((b == 32'd0) ? 2 : 33), name});
    #1 check({name, "_stall_T"}, 64'(stallreq_o), 64'd1);
  endtask

  // Holds start until ready, scrambling operands to prove they are ignored.
  task automatic complete(input string name);
    logic got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      #1;
      if (ready_o) begin
        got = 1'b1;
      end else begin
        check({name, "_stall"}, 64'(stallreq_o), 64'd1);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no ready_o expected ready within 60 cycles", name);
      sb.delete();
    end else begin
      check({name, "_stall_end"}, 64'(stallreq_o), 64'd0);
    end
    start_i = 1'b0;
    @(negedge clk);
    #1;
    check({name, "_idle_ready"}, 64'(ready_o), 64'd0);
    check({name, "_idle_result"}, result_o, 64'd0);
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input string name);
    issue(s, a, b, name);
    complete(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    int rises_before;
    logic s;
    logic [31:0] a, b;

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    run_div(1'b0, 32'd1234, 32'd0, "div_by_zero");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");

    // Cancel mid-flight; the pending expectation is withdrawn.
    issue(1'b0, 32'd1000, 32'd3, "annul");
    rises_before = rise_cnt;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1 check("annul_stall", 64'(stallreq_o), 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (40) @(negedge clk);
    check("annul_no_ready", 64'(rise_cnt - rises_before), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, "divu_9_3");

    // Reset mid-division with start held; the divider restarts from idle.
    issue(1'b0, 32'd5000, 32'd13, "rst_mid");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1 check("rst_stall", 64'(stallreq_o), 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    #1;
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    rst = 1'b0;
    sb.push_back('{ref_div(1'b0, opdata1_i, opdata2_i), cyc + 33, "rst_restart"});
    complete("rst_restart");

    for (int i = 0; i < 12; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 100);
      run_div(s, a, b, $sformatf("rand%0d", i));
    end

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
